// File: rtl/rs_syndrome_seq_pkg.sv
// Shared constants, state encoding and GF(8) helpers for the RS(7,5) syndrome sequencer.
package rs_syndrome_seq_pkg;

   localparam int SW  = 3;
   localparam int N   = 7;
   localparam int FCR = 1;

   localparam logic [SW:0]   PRIM_POLY = 4'b1011;
   localparam logic [SW-1:0] ALPHA     = 3'b010;
   localparam logic [2:0]    N_CNT     = 3'(N);
   // alpha has order 7, so exponents are reduced mod 7 up front
   localparam logic [2:0]    EXP0      = 3'(FCR % 7);
   localparam logic [2:0]    EXP1      = 3'((FCR + 1) % 7);

   typedef enum logic [1:0] {
      ACC0 = 2'd0,
      ACC1 = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] v);
      return {v[SW-2:0], 1'b0} ^ (v[SW-1] ? PRIM_POLY[SW-1:0] : '0);
   endfunction

endpackage

// File: rtl/rs_syndrome_seq_if.sv
// Symbol-in / syndrome-out handshake bundle; frame_err exists only with RS_SYND_FRAMECHK_EN.
interface rs_syndrome_seq_if;
   import rs_syndrome_seq_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] in_sym;
   logic          in_last;
   logic          synd_valid;
   logic          synd_ready;
   logic [SW-1:0] synd0;
   logic [SW-1:0] synd1;
   logic          synd_zero;
`ifdef RS_SYND_FRAMECHK_EN
   logic          frame_err;

   modport master (output in_valid, in_sym, in_last, synd_ready,
                   input  in_ready, synd_valid, synd0, synd1, synd_zero, frame_err);
   modport slave  (input  in_valid, in_sym, in_last, synd_ready,
                   output in_ready, synd_valid, synd0, synd1, synd_zero, frame_err);
`else
   modport master (output in_valid, in_sym, in_last, synd_ready,
                   input  in_ready, synd_valid, synd0, synd1, synd_zero);
   modport slave  (input  in_valid, in_sym, in_last, synd_ready,
                   output in_ready, synd_valid, synd0, synd1, synd_zero);
`endif

endinterface

// File: rtl/rs_syndrome_seq_gf_mul.sv
// Combinational GF(8) multiply of a vector-form operand by alpha^k (k in 0..6).
module rs_gf_const_mul
   import rs_syndrome_seq_pkg::*;
(
   input  logic [SW-1:0] a,
   input  logic [2:0]    k,
   output logic [SW-1:0] p
);

   always_comb begin
      p = a;
      for (int i = 0; i < 7; i++) begin
         if (3'(i) < k) p = gf_xtime(p);
      end
   end

endmodule

// File: rtl/rs_syndrome_seq.sv
// RS(7,5) syndrome generator: Horner evaluation at alpha^FCR and alpha^(FCR+1)
// sharing one constant multiplier. Optional frame-length check: RS_SYND_FRAMECHK_EN.
//
// state | meaning
// ACC0  | waiting for a symbol; on handshake fold it into acc0
// ACC1  | fold the captured symbol into acc1 using the shared multiplier
// DONE  | syndromes presented, held until accepted
module rs_syndrome_seq
   import rs_syndrome_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   rs_syndrome_seq_if.slave bus
);

   state_e        state_q, state_d;
   logic [SW-1:0] acc0_q, acc0_d, acc1_q, acc1_d, sym_q, sym_d;
   logic [2:0]    cnt_q, cnt_d, cnt_inc;
   logic          in_ready_q, in_ready_d;
   logic          synd_valid_q, synd_valid_d;
   logic [SW-1:0] synd0_q, synd0_d, synd1_q, synd1_d;
   logic          synd_zero_q, synd_zero_d;
   logic [SW-1:0] mul_a, mul_p, add_b, sum;
   logic [2:0]    mul_k;
   logic          hs, last_sym;
`ifdef RS_SYND_FRAMECHK_EN
   logic          err_pend_q, err_pend_d, early_q, early_d, frame_err_q, frame_err_d;
`else
   logic          unused_in_last;
   assign unused_in_last = bus.in_last;
`endif

   assign hs      = bus.in_valid & in_ready_q;
   assign cnt_inc = cnt_q + 3'd1;

   // operand muxes steer the single multiplier between the two accumulators
   always_comb begin
      mul_a = (state_q == ACC1) ? acc1_q : acc0_q;
      mul_k = (state_q == ACC1) ? EXP1   : EXP0;
      add_b = (state_q == ACC1) ? sym_q  : bus.in_sym;
      sum   = mul_p ^ add_b;
   end

   rs_gf_const_mul u_mul (
      .a (mul_a),
      .k (mul_k),
      .p (mul_p)
   );

`ifdef RS_SYND_FRAMECHK_EN
   assign last_sym = (cnt_q == N_CNT) | early_q;
`else
   assign last_sym = (cnt_q == N_CNT);
`endif

   always_comb begin
      state_d      = state_q;
      acc0_d       = acc0_q;
      acc1_d       = acc1_q;
      sym_d        = sym_q;
      cnt_d        = cnt_q;
      in_ready_d   = in_ready_q;
      synd_valid_d = synd_valid_q;
      synd0_d      = synd0_q;
      synd1_d      = synd1_q;
      synd_zero_d  = synd_zero_q;
`ifdef RS_SYND_FRAMECHK_EN
      err_pend_d   = err_pend_q;
      early_d      = early_q;
      frame_err_d  = frame_err_q;
`endif
      case (state_q)
         ACC0: begin
            if (hs) begin
               acc0_d     = sum;
               sym_d      = bus.in_sym;
               cnt_d      = (cnt_q == N_CNT) ? cnt_q : cnt_inc;
               in_ready_d = 1'b0;
               state_d    = ACC1;
`ifdef RS_SYND_FRAMECHK_EN
               if (bus.in_last != (cnt_inc == N_CNT)) err_pend_d = 1'b1;
               if (bus.in_last) early_d = 1'b1;
`endif
            end
         end
         ACC1: begin
            acc1_d = sum;
            if (last_sym) begin
               state_d      = DONE;
               synd_valid_d = 1'b1;
               synd0_d      = acc0_q;
               synd1_d      = sum;
               synd_zero_d  = (acc0_q == '0) && (sum == '0);
`ifdef RS_SYND_FRAMECHK_EN
               frame_err_d  = err_pend_q;
`endif
            end else begin
               state_d    = ACC0;
               in_ready_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.synd_ready) begin
               state_d      = ACC0;
               acc0_d       = '0;
               acc1_d       = '0;
               cnt_d        = '0;
               in_ready_d   = 1'b1;
               synd_valid_d = 1'b0;
               synd0_d      = '0;
               synd1_d      = '0;
               synd_zero_d  = 1'b0;
`ifdef RS_SYND_FRAMECHK_EN
               err_pend_d   = 1'b0;
               early_d      = 1'b0;
               frame_err_d  = 1'b0;
`endif
            end
         end
         default: state_d = ACC0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACC0;
         acc0_q       <= '0;
         acc1_q       <= '0;
         sym_q        <= '0;
         cnt_q        <= '0;
         in_ready_q   <= 1'b1;
         synd_valid_q <= 1'b0;
         synd0_q      <= '0;
         synd1_q      <= '0;
         synd_zero_q  <= 1'b0;
`ifdef RS_SYND_FRAMECHK_EN
         err_pend_q   <= 1'b0;
         early_q      <= 1'b0;
         frame_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         acc0_q       <= acc0_d;
         acc1_q       <= acc1_d;
         sym_q        <= sym_d;
         cnt_q        <= cnt_d;
         in_ready_q   <= in_ready_d;
         synd_valid_q <= synd_valid_d;
         synd0_q      <= synd0_d;
         synd1_q      <= synd1_d;
         synd_zero_q  <= synd_zero_d;
`ifdef RS_SYND_FRAMECHK_EN
         err_pend_q   <= err_pend_d;
         early_q      <= early_d;
         frame_err_q  <= frame_err_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.synd_valid = synd_valid_q;
   assign bus.synd0      = synd0_q;
   assign bus.synd1      = synd1_q;
   assign bus.synd_zero  = synd_zero_q;
`ifdef RS_SYND_FRAMECHK_EN
   assign bus.frame_err  = frame_err_q;
`endif

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Bench for rs_syndrome_seq: direct-sum syndrome model plus directed frames.
module tb_rs_syndrome_seq;

   typedef logic [2:0] frame_t [7];

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [2:0] exp_s0, exp_s1;
   logic       exp_z;
`ifdef RS_SYND_FRAMECHK_EN
   logic       exp_ferr;
`endif

   rs_syndrome_seq_if bus ();

   rs_syndrome_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // general GF(8) product, polynomial x^3+x+1
   function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
      logic [2:0] r;
      logic [2:0] x;
      r = 3'b000;
      x = a;
      for (int i = 0; i < 3; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[1:0], 1'b0} ^ (x[2] ? 3'b011 : 3'b000);
      end
      return r;
   endfunction

   function automatic logic [2:0] gf_pow(input int e);
      logic [2:0] r;
      r = 3'b001;
      for (int i = 0; i < e; i++) r = gf_mul(r, 3'b010);
      return r;
   endfunction

   // S_j = sum over symbols of r_i * alpha^((FCR+j)*deg_i), first symbol has highest degree
   function automatic logic [2:0] model_synd(input frame_t f, input int len, input int j);
      logic [2:0] s;
      s = 3'b000;
      for (int i = 0; i < len; i++)
         s = s ^ gf_mul(f[i], gf_pow((1 + j) * (len - 1 - i)));
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // every cycle the syndromes are presented they must match the model
   always @(negedge clk) begin
      if (rst_n && bus.synd_valid) begin
         chk("synd0", int'(bus.synd0), int'(exp_s0));
         chk("synd1", int'(bus.synd1), int'(exp_s1));
         chk("synd_zero", int'(bus.synd_zero), int'(exp_z));
         chk("in_ready_while_valid", int'(bus.in_ready), 0);
`ifdef RS_SYND_FRAMECHK_EN
         chk("frame_err", int'(bus.frame_err), int'(exp_ferr));
`endif
      end
   end

   // called at a negedge; returns at the negedge after the consuming edge
   task automatic send_sym(input logic [2:0] sym, input bit last, input bit gaps);
      logic rdy;
      int   tmo;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sym   = sym;
      bus.in_last  = last;
      tmo = 0;
      forever begin
         rdy = bus.in_ready;
         @(negedge clk);
         if (rdy) break;
         tmo++;
         if (tmo > 50) begin
            chk("in_ready_timeout", 0, 1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input frame_t f, input int len, input bit gaps);
      exp_s0 = model_synd(f, len, 0);
      exp_s1 = model_synd(f, len, 1);
      exp_z  = (exp_s0 == 3'b000) && (exp_s1 == 3'b000);
`ifdef RS_SYND_FRAMECHK_EN
      exp_ferr = (len != 7);
`endif
      for (int i = 0; i < len; i++) send_sym(f[i], (i == len - 1), gaps);
      chk("latency_t", int'(bus.synd_valid), 0);
      @(negedge clk);
      chk("latency_t1", int'(bus.synd_valid), 1);
   endtask

   task automatic accept(input int hold);
      logic [2:0] s0, s1;
      s0 = bus.synd0;
      s1 = bus.synd1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", int'(bus.synd_valid), 1);
         chk("bp_stable0", int'(bus.synd0), int'(s0));
         chk("bp_stable1", int'(bus.synd1), int'(s1));
      end
      bus.synd_ready = 1'b1;
      @(negedge clk);
      bus.synd_ready = 1'b0;
      chk("accept_valid_low", int'(bus.synd_valid), 0);
      chk("accept_in_ready", int'(bus.in_ready), 1);
   endtask

   frame_t f_zero, f_deg0, f_deg6, f_mix;

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_s0 = '0;
      exp_s1 = '0;
      exp_z  = 1'b0;
`ifdef RS_SYND_FRAMECHK_EN
      exp_ferr = 1'b0;
`endif
      f_zero = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      f_deg0 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      f_deg6 = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      f_mix  = '{3'd3, 3'd5, 3'd0, 3'd7, 3'd2, 3'd6, 3'd1};
      bus.in_valid = 1'b0;
      bus.in_sym = 3'd0;
      bus.in_last = 1'b0;
      bus.synd_ready = 1'b0;
      rst_n = 1'b0;

      chk("pin_zero_s0", int'(model_synd(f_zero, 7, 0)), 0);
      chk("pin_deg0_s1", int'(model_synd(f_deg0, 7, 1)), 1);
      chk("pin_deg6_s0", int'(model_synd(f_deg6, 7, 0)), 5);
      chk("pin_deg6_s1", int'(model_synd(f_deg6, 7, 1)), 7);

      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_synd_valid", int'(bus.synd_valid), 0);
      chk("rst_synd0", int'(bus.synd0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      send_frame(f_zero, 7, 1'b0);
      chk("zero_lit_zero", int'(bus.synd_zero), 1);
      accept(0);

      send_frame(f_deg0, 7, 1'b0);
      chk("deg0_lit_s0", int'(bus.synd0), 1);
      chk("deg0_lit_s1", int'(bus.synd1), 1);
      accept(0);

      send_frame(f_deg6, 7, 1'b0);
      chk("deg6_lit_s0", int'(bus.synd0), 5);
      chk("deg6_lit_s1", int'(bus.synd1), 7);
      accept(10);

      send_frame(f_deg0, 7, 1'b0);
      chk("deg0b_lit_s0", int'(bus.synd0), 1);
      accept(0);

      send_frame(f_mix, 7, 1'b0);
      accept(0);
      send_frame(f_mix, 7, 1'b1);
      accept(2);

      for (int i = 0; i < 3; i++) send_sym(f_mix[i], 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", int'(bus.in_ready), 1);
      chk("midrst_valid", int'(bus.synd_valid), 0);
      chk("midrst_synd1", int'(bus.synd1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(f_zero, 7, 1'b0);
      chk("postrst_s0", int'(bus.synd0), 0);
      accept(0);

`ifdef RS_SYND_FRAMECHK_EN
      send_frame(f_mix, 5, 1'b0);
      chk("early_last_err", int'(bus.frame_err), 1);
      accept(0);
      send_frame(f_mix, 7, 1'b0);
      chk("full_frame_err", int'(bus.frame_err), 0);
      accept(0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
